// File: rtl/mux_probe_checker.sv
// mux_probe_checker
// -----------------
// Self-checking exerciser for the 2:1 multiplexer probe block. It steps the
// mux drive {S,I1,I0} through all eight combinations. For each vector it
// waits SETTLE_CYCLES clocks, samples the 9-bit probe word and compares it
// with the expected word. It reports a pass/fail verdict, a mismatch count
// and the first failing vector together with its XOR mask.
//
// Parameters:
//   SETTLE_CYCLES   clocks between driving a vector and sampling it (0..15)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           level; sampled only in IDLE to launch a sweep
//   S_o/I0_o/I1_o   registered mux drive, {S_o,I1_o,I0_o} = vector counter
//   probe_i[8:0]    probe word returned by the mux (combinational from drive)
//   busy            high while a sweep is in progress (SETTLE/CHECK/DONE)
//   done            one-cycle pulse at sweep end
//   pass            verdict, valid from done until the next start
//   err_cnt[3:0]    number of mismatching vectors
//   first_fail_vec  {S,I1,I0} of the first mismatch, 0 if none
//   first_fail_bits observed XOR expected of the first mismatch, 0 if none
//   mux_y           decoded mux output from the last CHECK
//
// Build option:
//   MUX_PROBE_STOP_ON_FAIL_EN  when defined, the first mismatching CHECK ends
//                              the sweep immediately.

module mux_probe_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       S_o,
  output logic       I0_o,
  output logic       I1_o,
  input  logic [8:0] probe_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail_vec,
  output logic [8:0] first_fail_bits,
  output logic       mux_y
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
  // With no settle time a freshly driven vector is checked on the next edge.
  localparam state_t LP_AFTER_DRIVE = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_v;
  logic [3:0] r_settle_cnt;
  logic [3:0] r_err_cnt;
  logic [2:0] r_first_fail_vec;
  logic [8:0] r_first_fail_bits;
  logic       r_done;
  logic       r_pass;
  logic       r_mux_y;

  logic [8:0] w_expected;
  logic [8:0] w_diff;
  logic       w_mismatch;
  logic       w_last_vec;
  logic       w_stop;
  logic       w_end_sweep;

  // Expected probe word for the current drive, bit 8 down to 0.
  assign w_expected = {1'b1,
                       r_v[0] & ~r_v[2],
                       r_v[1] & r_v[2],
                       ~r_v[2],
                       {3{r_v[2]}},
                       r_v[1],
                       r_v[0]};
  assign w_diff      = probe_i ^ w_expected;
  assign w_mismatch  = |w_diff;
  assign w_last_vec  = (r_v == 3'd7);

`ifdef MUX_PROBE_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  assign w_end_sweep = w_last_vec | w_stop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = LP_AFTER_DRIVE;
        end
      end
      ST_SETTLE: begin
        // The counter is loaded with SETTLE_CYCLES, so the last settle cycle
        // is the one that sees a count of 1.
        if (r_settle_cnt <= 4'd1) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_end_sweep) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = LP_AFTER_DRIVE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: vector counter, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v               <= 3'd0;
      r_settle_cnt      <= 4'd0;
      r_err_cnt         <= 4'd0;
      r_first_fail_vec  <= 3'd0;
      r_first_fail_bits <= 9'd0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_mux_y           <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_v               <= 3'd0;
            r_settle_cnt      <= LP_SETTLE;
            r_err_cnt         <= 4'd0;
            r_first_fail_vec  <= 3'd0;
            r_first_fail_bits <= 9'd0;
            r_pass            <= 1'b0;
          end
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
        end
        ST_CHECK: begin
          r_mux_y <= probe_i[6] | probe_i[7];
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + 4'd1;
            // err_cnt is cleared at start, so zero means no earlier mismatch.
            if (r_err_cnt == 4'd0) begin
              r_first_fail_vec  <= r_v;
              r_first_fail_bits <= w_diff;
            end
          end
          if (!w_end_sweep) begin
            r_v          <= r_v + 3'd1;
            r_settle_cnt <= LP_SETTLE;
          end
        end
        ST_DONE: begin
          // err_cnt already holds the final CHECK result here.
          r_done <= 1'b1;
          r_pass <= (r_err_cnt == 4'd0);
        end
        default: begin
        end
      endcase
    end
  end

  assign S_o             = r_v[2];
  assign I1_o            = r_v[1];
  assign I0_o            = r_v[0];
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_cnt         = r_err_cnt;
  assign first_fail_vec  = r_first_fail_vec;
  assign first_fail_bits = r_first_fail_bits;
  assign mux_y           = r_mux_y;

endmodule

// File: tb/tb_mux_probe_checker.sv
// tb_mux_probe_checker
// --------------------
// Directed bench for mux_probe_checker. Two instances share one clock: u_dut
// with the default settle time and u_fast with SETTLE_CYCLES=0. Each has a
// behavioural mux probe model with injectable stuck-at-0 and inversion masks.

module tb_mux_probe_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-parameter instance.
  logic       rst_n;
  logic       start;
  logic       s_o, i0_o, i1_o;
  logic [8:0] probe;
  logic       busy, done, pass, mux_y;
  logic [3:0] err_cnt;
  logic [2:0] ffv;
  logic [8:0] ffb;
  logic [8:0] stuck0_mask;

  // SETTLE_CYCLES=0 instance.
  logic       f_rst_n;
  logic       f_start;
  logic       f_s_o, f_i0_o, f_i1_o;
  logic [8:0] f_probe;
  logic       f_busy, f_done, f_pass, f_mux_y;
  logic [3:0] f_err_cnt;
  logic [2:0] f_ffv;
  logic [8:0] f_ffb;
  logic [8:0] f_inv_mask;

  // Hand-computed probe words of a healthy mux, indexed by {S,I1,I0}.
  function automatic logic [8:0] good_word(input logic [2:0] v);
    logic [8:0] w;
    case (v)
      3'd0:    w = 9'h120;
      3'd1:    w = 9'h1A1;
      3'd2:    w = 9'h122;
      3'd3:    w = 9'h1A3;
      3'd4:    w = 9'h11C;
      3'd5:    w = 9'h11D;
      3'd6:    w = 9'h15E;
      default: w = 9'h15F;
    endcase
    return w;
  endfunction

  assign probe   = good_word({s_o, i1_o, i0_o}) & ~stuck0_mask;
  assign f_probe = good_word({f_s_o, f_i1_o, f_i0_o}) ^ f_inv_mask;

  mux_probe_checker u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .S_o             (s_o),
    .I0_o            (i0_o),
    .I1_o            (i1_o),
    .probe_i         (probe),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_fail_vec  (ffv),
    .first_fail_bits (ffb),
    .mux_y           (mux_y)
  );

  mux_probe_checker #(.SETTLE_CYCLES(0)) u_fast (
    .clk             (clk),
    .rst_n           (f_rst_n),
    .start           (f_start),
    .S_o             (f_s_o),
    .I0_o            (f_i0_o),
    .I1_o            (f_i1_o),
    .probe_i         (f_probe),
    .busy            (f_busy),
    .done            (f_done),
    .pass            (f_pass),
    .err_cnt         (f_err_cnt),
    .first_fail_vec  (f_ffv),
    .first_fail_bits (f_ffb),
    .mux_y           (f_mux_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start (sampled at edge 0), then watches 40 more edges, sampling
  // done on each falling edge. Optionally raises start again so that it is
  // sampled at edge restart_at.
  task automatic run_sweep(input int restart_at, output int done_edge, output int done_cnt);
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      start = (n == restart_at - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int de;
    int dc;
    int n_done;

    rst_n       = 1'b0;
    start       = 1'b0;
    stuck0_mask = 9'h000;
    f_rst_n     = 1'b0;
    f_start     = 1'b0;
    f_inv_mask  = 9'h020;
    #1;
    check("reset_outputs",
          32'({s_o, i0_o, i1_o, busy, done, pass, err_cnt, ffv, ffb, mux_y}), 32'd0);
    check("reset_fast_outputs",
          32'({f_s_o, f_i0_o, f_i1_o, f_busy, f_done, f_pass, f_err_cnt, f_ffv, f_ffb, f_mux_y}),
          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    f_rst_n = 1'b1;
    @(negedge clk);
    $display("step reset: checked outputs zero");

    // Healthy mux.
    run_sweep(0, de, dc);
    check("good_done_edge", 32'(de), 32'd25);
    check("good_done_count", 32'(dc), 32'd1);
    check("good_pass", 32'(pass), 32'd1);
    check("good_err_cnt", 32'(err_cnt), 32'd0);
    check("good_ffv", 32'(ffv), 32'd0);
    check("good_ffb", 32'(ffb), 32'd0);
    check("good_mux_y", 32'(mux_y), 32'd1);
    check("good_idle", 32'(busy), 32'd0);
    check("good_drive_hold", 32'({s_o, i1_o, i0_o}), 32'd7);
    $display("step good: done_edge=%0d err_cnt=%0d pass=%0b", de, err_cnt, pass);

    // probe[8] stuck at 0: every vector fails.
    stuck0_mask = 9'h100;
    run_sweep(0, de, dc);
    check("b8_done_edge", 32'(de), 32'd25);
    check("b8_err_cnt", 32'(err_cnt), 32'd8);
    check("b8_pass", 32'(pass), 32'd0);
    check("b8_ffv", 32'(ffv), 32'd0);
    check("b8_ffb", 32'(ffb), 32'h100);
    $display("step stuck8: err_cnt=%0d ffv=%0d ffb=%03h", err_cnt, ffv, ffb);

    // probe[6] stuck at 0: only vectors 6 and 7 drive it high.
    stuck0_mask = 9'h040;
    run_sweep(0, de, dc);
    check("b6_err_cnt", 32'(err_cnt), 32'd2);
    check("b6_pass", 32'(pass), 32'd0);
    check("b6_ffv", 32'(ffv), 32'd6);
    check("b6_ffb", 32'(ffb), 32'h040);
    check("b6_mux_y", 32'(mux_y), 32'd0);
    $display("step stuck6: err_cnt=%0d ffv=%0d ffb=%03h", err_cnt, ffv, ffb);

    // Healthy mux, start re-pulsed at edge 10 must be ignored.
    stuck0_mask = 9'h000;
    run_sweep(10, de, dc);
    check("restart_done_edge", 32'(de), 32'd25);
    check("restart_done_count", 32'(dc), 32'd1);
    check("restart_pass", 32'(pass), 32'd1);
    $display("step restart: done_edge=%0d done_count=%0d", de, dc);

    // Reset mid-sweep at edge 12 with a failing probe.
    stuck0_mask = 9'h100;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_pre_err_cnt", 32'(err_cnt), 32'd4);
    check("abort_pre_drive", 32'({s_o, i1_o, i0_o}), 32'd4);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs",
          32'({s_o, i0_o, i1_o, busy, done, pass, err_cnt, ffv, ffb, mux_y}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    stuck0_mask = 9'h000;
    run_sweep(0, de, dc);
    check("after_abort_done_edge", 32'(de), 32'd25);
    check("after_abort_pass", 32'(pass), 32'd1);
    check("after_abort_err_cnt", 32'(err_cnt), 32'd0);
    $display("step abort: clean sweep done_edge=%0d pass=%0b", de, pass);

    // Zero settle time with probe[5] inverted: vector 0 already fails.
    de = -1;
    dc = 0;
    @(negedge clk);
    f_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (f_done) begin
        dc++;
        if (de < 0) de = n;
      end
    end
`ifdef MUX_PROBE_STOP_ON_FAIL_EN
    check("fast_done_edge", 32'(de), 32'd2);
    check("fast_err_cnt", 32'(f_err_cnt), 32'd1);
`else
    check("fast_done_edge", 32'(de), 32'd9);
    check("fast_err_cnt", 32'(f_err_cnt), 32'd8);
`endif
    check("fast_done_count", 32'(dc), 32'd1);
    check("fast_pass", 32'(f_pass), 32'd0);
    check("fast_ffv", 32'(f_ffv), 32'd0);
    check("fast_ffb", 32'(f_ffb), 32'h020);
    $display("step fast: done_edge=%0d err_cnt=%0d ffb=%03h", de, f_err_cnt, f_ffb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
